// File: rtl/random_delay_gen.sv
// random_delay_gen
// Produces the randomised foreperiod (MIN_MS .. MIN_MS + 2^RAND_W - 1 ms) that
// the reaction timer waits through before lighting the LED. A free-running
// 16-bit Fibonacci LFSR is sampled when start is accepted, so the moment of
// the button press supplies the entropy.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; no delay in progress
//   RUN   | counting down ms_left, one ms per TICK_DIV clocks
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_ni      asynchronous active-low reset (deassertion synchronised outside)
//   start_i     single-cycle request to begin a delay, honoured only in IDLE
//   abort_i     single-cycle cancel, returns to IDLE without expiry
//   busy_o      high while a delay is running
//   expired_o   one-cycle pulse when the delay completes
//   delay_ms_o  delay latched at the last accepted start
module random_delay_gen #(
    parameter int unsigned    CLK_HZ   = 100_000_000,
    parameter int unsigned    TICK_DIV = 100_000,
    parameter int unsigned    MIN_MS   = 2000,
    parameter int unsigned    RAND_W   = 13,
    parameter int unsigned    CNT_W    = 16,
    parameter logic [15:0]    SEED     = 16'hACE1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    output logic             busy_o,
    output logic             expired_o,
    output logic [CNT_W-1:0] delay_ms_o
);

    localparam int unsigned PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [63:0] MAX_DELAY = 64'(MIN_MS) + (64'd1 << RAND_W) - 64'd1;

    // Parameter sanity: refuse to elaborate a configuration that cannot work.
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("random_delay_gen: TICK_DIV must be at least 2");
    end
    if (RAND_W < 1 || RAND_W > 16) begin : g_bad_rand_w
        $error("random_delay_gen: RAND_W must be 1..16");
    end
    if (MAX_DELAY >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
        $error("random_delay_gen: CNT_W too narrow for MIN_MS + 2^RAND_W - 1");
    end
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("random_delay_gen: SEED must be nonzero");
    end
    if (CLK_HZ == 0) begin : g_bad_clk_hz
        $error("random_delay_gen: CLK_HZ must be nonzero");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q,     state_d;
    logic [15:0]        lfsr_q,      lfsr_d;
    logic [PRE_W-1:0]   prescaler_q, prescaler_d;
    logic [CNT_W-1:0]   ms_left_q,   ms_left_d;
    logic               busy_q,      busy_d;
    logic               expired_q,   expired_d;
    logic [CNT_W-1:0]   delay_ms_q,  delay_ms_d;
    logic [CNT_W-1:0]   delay_capture;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting left; never reaches zero from a
    // nonzero seed.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Uses the pre-shift LFSR value present in the accepting cycle.
    assign delay_capture = CNT_W'(MIN_MS) + CNT_W'(lfsr_q[RAND_W-1:0]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            prescaler_q <= '0;
            ms_left_q   <= '0;
            busy_q      <= 1'b0;
            expired_q   <= 1'b0;
            delay_ms_q  <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            prescaler_q <= prescaler_d;
            ms_left_q   <= ms_left_d;
            busy_q      <= busy_d;
            expired_q   <= expired_d;
            delay_ms_q  <= delay_ms_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        prescaler_d = prescaler_q;
        ms_left_d   = ms_left_q;
        busy_d      = busy_q;
        expired_d   = 1'b0;
        delay_ms_d  = delay_ms_q;

        case (state_q)
            IDLE: begin
                // abort wins over a simultaneous start
                if (start_i && !abort_i) begin
                    ms_left_d   = delay_capture;
                    delay_ms_d  = delay_capture;
                    prescaler_d = '0;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end
            end

            RUN: begin
                if (abort_i) begin
                    // Also wins over a final tick in the same cycle.
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    prescaler_d = '0;
                    ms_left_d   = '0;
                end else if (prescaler_q == TICK_LAST) begin
                    prescaler_d = '0;
                    if (ms_left_q > CNT_W'(1)) begin
                        ms_left_d = ms_left_q - CNT_W'(1);
                    end else begin
                        // ms_left of 0 (MIN_MS = 0 with zero random bits)
                        // is treated like 1 so the run always terminates.
                        ms_left_d = '0;
                        expired_d = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = IDLE;
                    end
                end else begin
                    prescaler_d = prescaler_q + PRE_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_o     = busy_q;
    assign expired_o  = expired_q;
    assign delay_ms_o = delay_ms_q;

endmodule

// File: tb/tb_random_delay_gen.sv
module tb_random_delay_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: small simulation parameters
    logic        rst_a_n, start_a, abort_a;
    logic        busy_a, exp_a;
    logic [15:0] dly_a;

    // Instance B: default timing parameters with an accelerated tick
    logic        rst_b_n, start_b, abort_b;
    logic        busy_b, exp_b;
    logic [15:0] dly_b;

    random_delay_gen #(
        .CLK_HZ  (100_000_000),
        .TICK_DIV(4),
        .MIN_MS  (2),
        .RAND_W  (3),
        .CNT_W   (16),
        .SEED    (16'hACE1)
    ) dut_a (
        .clk_i     (clk),
        .rst_ni    (rst_a_n),
        .start_i   (start_a),
        .abort_i   (abort_a),
        .busy_o    (busy_a),
        .expired_o (exp_a),
        .delay_ms_o(dly_a)
    );

    random_delay_gen #(
        .CLK_HZ  (100_000_000),
        .TICK_DIV(2),
        .MIN_MS  (2000),
        .RAND_W  (13),
        .CNT_W   (16),
        .SEED    (16'h1FFF)
    ) dut_b (
        .clk_i     (clk),
        .rst_ni    (rst_b_n),
        .start_i   (start_b),
        .abort_i   (abort_b),
        .busy_o    (busy_b),
        .expired_o (exp_b),
        .delay_ms_o(dly_b)
    );

    // Independent LFSR reference for instance A
    logic [15:0] ref_a;
    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) ref_a <= 16'hACE1;
        else          ref_a <= {ref_a[14:0], ref_a[15] ^ ref_a[13] ^ ref_a[12] ^ ref_a[10]};
    end

    // Counts expired pulses of A (value sampled at the edge ending the cycle)
    int exp_cnt_a = 0;
    always @(posedge clk) begin
        if (exp_a === 1'b1) exp_cnt_a++;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        start;
        logic        abort;
        logic        busy;
        logic        expired;
        logic [15:0] dly;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n;
        int busy_cnt;
        int cnt0;
        logic [15:0] exp_d;
        logic [15:0] keep_d;

        // D = 2 + 3'b001 = 3 ms -> 12 cycles; start repeated mid-run at idx 5
        for (int i = 0; i < 14; i++)
            tbl[i] = '{start: 1'b0, abort: 1'b0, busy: 1'b1, expired: 1'b0, dly: 16'd3};
        tbl[0].start    = 1'b1;
        tbl[5].start    = 1'b1;
        tbl[12].busy    = 1'b0;
        tbl[12].expired = 1'b1;
        tbl[13].busy    = 1'b0;

        rst_a_n = 1'b0; start_a = 1'b0; abort_a = 1'b0;
        rst_b_n = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        chk("reset_busy",    32'(busy_a), 32'd0);
        chk("reset_expired", 32'(exp_a),  32'd0);
        chk("reset_delay",   32'(dly_a),  32'd0);
        chk("reset_lfsr",    32'(dut_a.lfsr_q), 32'h0000ACE1);

        // Test 1: start in the first cycle after reset release
        rst_a_n = 1'b1;
        cnt0 = exp_cnt_a;
        for (int i = 0; i < 14; i++) begin
            start_a = tbl[i].start;
            abort_a = tbl[i].abort;
            step();
            start_a = 1'b0;
            abort_a = 1'b0;
            chk($sformatf("t1_busy[%0d]", i),    32'(busy_a), 32'(tbl[i].busy));
            chk($sformatf("t1_expired[%0d]", i), 32'(exp_a),  32'(tbl[i].expired));
            chk($sformatf("t1_delay[%0d]", i),   32'(dly_a),  32'(tbl[i].dly));
        end
        chk("t1_single_pulse", 32'(exp_cnt_a - cnt0), 32'd1);

        // Test 2: start after one LFSR step (59C3 -> D = 5)
        @(negedge clk); rst_a_n = 1'b0;
        @(negedge clk); rst_a_n = 1'b1;
        step();
        chk("t2_lfsr_step1", 32'(dut_a.lfsr_q), 32'h000059C3);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("t2_delay", 32'(dly_a), 32'd5);
        chk("t2_busy",  32'(busy_a), 32'd1);
        busy_cnt = 1;
        for (n = 1; n <= 100; n++) begin
            step();
            if (busy_a) busy_cnt++;
            if (exp_a) break;
        end
        chk("t2_expire_edges", 32'(n), 32'd20);
        chk("t2_busy_cycles",  32'(busy_cnt), 32'd20);

        // Back-to-back: start in the expired cycle
        exp_d = 16'd2 + {13'd0, ref_a[2:0]};
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("b2b_delay", 32'(dly_a),  32'(exp_d));
        chk("b2b_busy",  32'(busy_a), 32'd1);

        // Test 3: abort 6 cycles into the run
        for (int i = 0; i < 5; i++) step();
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("t3_busy_after_abort", 32'(busy_a), 32'd0);
        cnt0 = exp_cnt_a;
        for (int i = 0; i < 100; i++) begin
            step();
            chk($sformatf("lfsr_ref[%0d]", i), 32'(dut_a.lfsr_q), 32'(ref_a));
        end
        chk("t3_no_expired", 32'(exp_cnt_a - cnt0), 32'd0);
        chk("t3_delay_kept", 32'(dly_a), 32'(exp_d));

        // Test 4a: start and abort together in IDLE
        keep_d = dly_a;
        start_a = 1'b1; abort_a = 1'b1;
        step();
        start_a = 1'b0; abort_a = 1'b0;
        chk("t4_both_busy",  32'(busy_a), 32'd0);
        chk("t4_both_delay", 32'(dly_a),  32'(keep_d));
        step();
        chk("t4_both_stays_idle", 32'(busy_a), 32'd0);

        // Test 4b: abort coinciding with the final tick
        exp_d = 16'd2 + {13'd0, ref_a[2:0]};
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        cnt0 = exp_cnt_a;
        for (int i = 1; i < 4 * int'(exp_d); i++) step();
        chk("t4_busy_before_final", 32'(busy_a), 32'd1);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("t4_final_abort_busy",    32'(busy_a), 32'd0);
        chk("t4_final_abort_expired", 32'(exp_a),  32'd0);
        for (int i = 0; i < 5; i++) step();
        chk("t4_final_abort_no_pulse", 32'(exp_cnt_a - cnt0), 32'd0);

        // Test 5: asynchronous reset mid-run
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        step();
        step();
        @(posedge clk);
        #2 rst_a_n = 1'b0;
        #1;
        chk("t5_busy",    32'(busy_a), 32'd0);
        chk("t5_expired", 32'(exp_a),  32'd0);
        chk("t5_delay",   32'(dly_a),  32'd0);
        chk("t5_lfsr",    32'(dut_a.lfsr_q), 32'h0000ACE1);
        @(negedge clk);
        rst_a_n = 1'b1;
        cnt0 = exp_cnt_a;
        for (int i = 0; i < 30; i++) step();
        chk("t5_no_expired", 32'(exp_cnt_a - cnt0), 32'd0);

        // Test 6: maximum delay with default timing, TICK_DIV = 2
        @(negedge clk);
        rst_b_n = 1'b1;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        chk("t6_delay", 32'(dly_b),  32'd10191);
        chk("t6_busy",  32'(busy_b), 32'd1);
        busy_cnt = 1;
        for (n = 1; n <= 25000; n++) begin
            step();
            if (busy_b) busy_cnt++;
            if (exp_b) break;
        end
        chk("t6_expire_edges", 32'(n), 32'd20382);
        chk("t6_busy_cycles",  32'(busy_cnt), 32'd20382);
        step();
        chk("t6_pulse_width", 32'(exp_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
